// File: rtl/arith_pipe_if.sv
// Issue-side and writeback-side handshake bundle for arith_pipe.
// Signal suffixes are from the execution unit's point of view.
interface arith_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [TAG_W-1:0] issue_tag_i;
    logic [XLEN-1:0]  pc_i;
    logic [31:0]      inst_i;
    logic [XLEN-1:0]  rs1_value_i;
    logic [XLEN-1:0]  rs2_value_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [TAG_W-1:0] wb_tag_o;
    logic [XLEN-1:0]  wb_value_o;
    logic             wb_illegal_o;

    modport master (
        output issue_valid_i, issue_tag_i, pc_i, inst_i, rs1_value_i, rs2_value_i, wb_ready_i,
        input  issue_ready_o, wb_valid_o, wb_tag_o, wb_value_o, wb_illegal_o
    );

    modport slave (
        input  issue_valid_i, issue_tag_i, pc_i, inst_i, rs1_value_i, rs2_value_i, wb_ready_i,
        output issue_ready_o, wb_valid_o, wb_tag_o, wb_value_o, wb_illegal_o
    );
endinterface

// File: rtl/arith_pipe.sv
// Pipelined RV32I/RV64I integer execution unit: result is computed at issue and
// carried with its ROB tag through STAGES elastic, bubble-collapsing stages.
module arith_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          flush_i,
    arith_pipe_if.slave   bus,
    output logic          busy_o
);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];

    logic [XLEN-1:0] rs1, rs2, imm_i, imm_u, result;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [SHW-1:0]  shamt_i, shamt_r;
    logic            shift_lo_ok;
    logic            illegal;
    logic [STAGES-1:0] free;
    logic            accept;
    logic            unused_rd;

    assign rs1     = bus.rs1_value_i;
    assign rs2     = bus.rs2_value_i;
    assign funct3  = bus.inst_i[14:12];
    assign funct7  = bus.inst_i[31:25];
    assign imm_i   = XLEN'($signed(bus.inst_i[31:20]));
    assign imm_u   = XLEN'($signed({bus.inst_i[31:12], 12'b0}));
    assign shamt_i = bus.inst_i[20 +: SHW];
    assign shamt_r = rs2[SHW-1:0];
    // On RV64 inst[25] is shamt[5]; on RV32 it belongs to funct7 and must be 0.
    assign shift_lo_ok = (XLEN == 64) || !bus.inst_i[25];
    assign unused_rd   = ^bus.inst_i[11:7];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (opcode_e'(bus.inst_i[6:0]))
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: result = rs1 + imm_i;
                    3'b010: result = XLEN'($signed(rs1) < $signed(imm_i));
                    3'b011: result = XLEN'(rs1 < imm_i);
                    3'b100: result = rs1 ^ imm_i;
                    3'b110: result = rs1 | imm_i;
                    3'b111: result = rs1 & imm_i;
                    3'b001: begin
                        if (bus.inst_i[31:26] == 6'b000000 && shift_lo_ok) result = rs1 << shamt_i;
                        else illegal = 1'b1;
                    end
                    3'b101: begin
                        if (bus.inst_i[31:26] == 6'b000000 && shift_lo_ok)
                            result = rs1 >> shamt_i;
                        else if (bus.inst_i[31:26] == 6'b010000 && shift_lo_ok)
                            result = XLEN'($signed(rs1) >>> shamt_i);
                        else
                            illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: result = rs1 + rs2;
                        3'b001: result = rs1 << shamt_r;
                        3'b010: result = XLEN'($signed(rs1) < $signed(rs2));
                        3'b011: result = XLEN'(rs1 < rs2);
                        3'b100: result = rs1 ^ rs2;
                        3'b101: result = rs1 >> shamt_r;
                        3'b110: result = rs1 | rs2;
                        3'b111: result = rs1 & rs2;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    result = rs1 - rs2;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    result = XLEN'($signed(rs1) >>> shamt_r);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_LUI:            result = imm_u;
            OPC_AUIPC:          result = bus.pc_i + imm_u;
            OPC_JAL, OPC_JALR:  result = bus.pc_i + XLEN'(4);
            default:            illegal = 1'b1;
        endcase
        if (illegal) result = '0;
    end

    // A stage is free to load when it is empty or its content moves on this edge.
    always_comb begin : free_chain
        logic chain;
        chain = !stage_q[STAGES-1].valid || bus.wb_ready_i;
        free[STAGES-1] = chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            chain   = !stage_q[k].valid || chain;
            free[k] = chain;
        end
    end

    assign bus.issue_ready_o = free[0] && !flush_i;
    assign accept            = bus.issue_valid_i && bus.issue_ready_o;

    always_comb begin
        for (int k = 0; k < STAGES; k++) stage_d[k] = stage_q[k];
        if (free[0]) begin
            stage_d[0].valid   = accept;
            stage_d[0].illegal = illegal;
            stage_d[0].tag     = bus.issue_tag_i;
            stage_d[0].value   = result;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (free[k]) stage_d[k] = stage_q[k-1];
        end
        if (flush_i) begin
            for (int k = 0; k < STAGES; k++) stage_d[k].valid = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignment; payload is reset too so wb_tag_o/wb_value_o read 0 out of reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < STAGES; k++) busy_o = busy_o || stage_q[k].valid;
    end

    assign bus.wb_valid_o   = stage_q[STAGES-1].valid;
    assign bus.wb_illegal_o = stage_q[STAGES-1].illegal;
    assign bus.wb_tag_o     = stage_q[STAGES-1].tag;
    assign bus.wb_value_o   = stage_q[STAGES-1].value;
endmodule
